// File: rtl/dds_cmd_writer.sv
// dds_cmd_writer: host-side writer for the DDS control strobe bus.
// Takes one (channel, register, value) command per valid/ready handshake and
// serialises it onto ch_sw, data_out and one of four active-low strobes with
// programmable setup / pulse / hold timing. Every output comes from a flop.
module dds_cmd_writer #(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 4,
    parameter int HOLD_CYC  = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_ch,
    input  logic [1:0]  cmd_reg,
    input  logic [15:0] cmd_data,
    output logic        ch_sw,
    output logic        wave,
    output logic        fre_h,
    output logic        fre_l,
    output logic        pha,
    output logic [7:0]  data_out,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [1:0] REG_WAVE = 2'd0;
    localparam logic [1:0] REG_FREQ = 2'd1;
    localparam logic [1:0] REG_PHA  = 2'd2;
    localparam logic [1:0] REG_RSVD = 2'd3;

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        second_byte_q, second_byte_d;   // freq low byte still to send
    logic [1:0]  reg_q, reg_d;
    logic [7:0]  lo_q, lo_d;                     // captured cmd_data[7:0]

    logic        cmd_ready_q, cmd_ready_d;
    logic        ch_sw_q, ch_sw_d;
    logic        wave_q, wave_d;
    logic        fre_h_q, fre_h_d;
    logic        fre_l_q, fre_l_d;
    logic        pha_q, pha_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        accept;
    logic        in_strobe;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        second_byte_d = second_byte_q;
        reg_d         = reg_q;
        lo_d          = lo_q;
        ch_sw_d       = ch_sw_q;
        data_out_d    = data_out_q;
        err_d         = 1'b0;
        // cmd_ready_q is only high in IDLE and DONE, so this is the handshake.
        accept        = cmd_valid & cmd_ready_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    reg_d = cmd_reg;
                    lo_d  = cmd_data[7:0];
                    if (cmd_reg == REG_RSVD) begin
                        // Rejected: no bus activity, stay ready.
                        err_d = 1'b1;
                    end else begin
                        state_d       = S_SETUP;
                        cnt_d         = SETUP_LD;
                        second_byte_d = (cmd_reg == REG_FREQ);
                        ch_sw_d       = cmd_ch;
                        data_out_d    = (cmd_reg == REG_FREQ) ? cmd_data[15:8]
                                                              : cmd_data[7:0];
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_STROBE;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_STROBE: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == 8'd0) begin
                    if (second_byte_q) begin
                        // High byte done; go round again for the low byte.
                        state_d       = S_SETUP;
                        cnt_d         = SETUP_LD;
                        second_byte_d = 1'b0;
                        data_out_d    = lo_q;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobes are decoded from the next state so they land in flops and
        // can never glitch; at most one is low since reg_q selects one.
        in_strobe   = (state_d == S_STROBE);
        wave_d      = ~(in_strobe && (reg_q == REG_WAVE));
        fre_h_d     = ~(in_strobe && (reg_q == REG_FREQ) && second_byte_q);
        fre_l_d     = ~(in_strobe && (reg_q == REG_FREQ) && !second_byte_q);
        pha_d       = ~(in_strobe && (reg_q == REG_PHA));
        done_d      = (state_d == S_DONE);
        cmd_ready_d = (state_d == S_IDLE) || (state_d == S_DONE);
    end

    // Control state and all bus outputs, forced to safe values on reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= 8'd0;
            second_byte_q <= 1'b0;
            cmd_ready_q   <= 1'b0;
            ch_sw_q       <= 1'b0;
            wave_q        <= 1'b1;
            fre_h_q       <= 1'b1;
            fre_l_q       <= 1'b1;
            pha_q         <= 1'b1;
            data_out_q    <= 8'h00;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            second_byte_q <= second_byte_d;
            cmd_ready_q   <= cmd_ready_d;
            ch_sw_q       <= ch_sw_d;
            wave_q        <= wave_d;
            fre_h_q       <= fre_h_d;
            fre_l_q       <= fre_l_d;
            pha_q         <= pha_d;
            data_out_q    <= data_out_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    // Captured command fields; only meaningful while a command is in flight.
    always_ff @(posedge sys_clk) begin
        reg_q <= reg_d;
        lo_q  <= lo_d;
    end

    assign cmd_ready = cmd_ready_q;
    assign ch_sw     = ch_sw_q;
    assign wave      = wave_q;
    assign fre_h     = fre_h_q;
    assign fre_l     = fre_l_q;
    assign pha       = pha_q;
    assign data_out  = data_out_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dds_cmd_writer.sv
// Testbench for dds_cmd_writer: default-timing instance (A) and a 1/1/1
// timing instance (B), table-driven command vectors plus hand-written
// sequences for reserved commands, back-to-back handshakes and reset.
module tb_dds_cmd_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        va = 1'b0;
    logic        vb = 1'b0;
    logic        cmd_ch = 1'b0;
    logic [1:0]  cmd_reg = 2'd0;
    logic [15:0] cmd_data = 16'h0000;

    logic        a_ready, a_ch_sw, a_wave, a_fre_h, a_fre_l, a_pha, a_done, a_err;
    logic [7:0]  a_data;
    logic        b_ready, b_ch_sw, b_wave, b_fre_h, b_fre_l, b_pha, b_done, b_err;
    logic [7:0]  b_data;
    logic [15:0] obs_a, obs_b;

    int n_chk  = 0;
    int n_pass = 0;

    logic       last_ch [2];
    logic [7:0] last_d  [2];

    always #5 clk = ~clk;

    dds_cmd_writer dut_a (
        .sys_clk(clk), .sys_rst(rst), .cmd_valid(va), .cmd_ready(a_ready),
        .cmd_ch(cmd_ch), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
        .ch_sw(a_ch_sw), .wave(a_wave), .fre_h(a_fre_h), .fre_l(a_fre_l),
        .pha(a_pha), .data_out(a_data), .done(a_done), .err(a_err)
    );

    dds_cmd_writer #(.SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) dut_b (
        .sys_clk(clk), .sys_rst(rst), .cmd_valid(vb), .cmd_ready(b_ready),
        .cmd_ch(cmd_ch), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
        .ch_sw(b_ch_sw), .wave(b_wave), .fre_h(b_fre_h), .fre_l(b_fre_l),
        .pha(b_pha), .data_out(b_data), .done(b_done), .err(b_err)
    );

    assign obs_a = {a_ch_sw, a_wave, a_fre_h, a_fre_l, a_pha, a_data, a_ready, a_done, a_err};
    assign obs_b = {b_ch_sw, b_wave, b_fre_h, b_fre_l, b_pha, b_data, b_ready, b_done, b_err};

    typedef struct {
        string       name;
        logic        ch;
        logic [1:0]  rg;
        logic [15:0] data;
        logic [7:0]  b0;   // byte expected in the first (or only) phase
        logic [7:0]  b1;   // byte expected in the freq low-byte phase
    } vec_t;

    vec_t tbl [3];

    function automatic logic [15:0] mk(logic ch, logic w, logic fh, logic fl, logic p,
                                       logic [7:0] d, logic r, logic dn, logic e);
        return {ch, w, fh, fl, p, d, r, dn, e};
    endfunction

    function automatic logic [15:0] obs(int sel);
        return (sel == 1) ? obs_b : obs_a;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command on instance sel and compare every output cycle by
    // cycle through done, then the return to idle.
    task automatic run_cmd(input int sel, input vec_t v, input int s, input int p, input int h);
        int nb, len, total, b, pos;
        logic stb;
        logic [7:0] byt;
        logic [15:0] exp;
        nb = (v.rg == 2'd1) ? 2 : 1;
        len = s + p + h;
        total = nb * len + 1;
        cmd_ch = v.ch; cmd_reg = v.rg; cmd_data = v.data;
        if (sel == 1) vb = 1'b1; else va = 1'b1;
        tick();
        va = 1'b0; vb = 1'b0;
        cmd_ch = ~v.ch; cmd_data = ~v.data; cmd_reg = 2'd3;
        for (int i = 1; i <= total; i++) begin
            if (i == total) begin
                exp = mk(v.ch, 1, 1, 1, 1, (nb == 2) ? v.b1 : v.b0, 1, 1, 0);
            end else begin
                b = (i - 1) / len;
                pos = (i - 1) % len;
                byt = (b == 0) ? v.b0 : v.b1;
                stb = (pos >= s) && (pos < s + p);
                exp = mk(v.ch, !(stb && v.rg == 2'd0),
                         !(stb && v.rg == 2'd1 && b == 0),
                         !(stb && v.rg == 2'd1 && b == 1),
                         !(stb && v.rg == 2'd2), byt, 0, 0, 0);
            end
            check($sformatf("%s_T+%0d", v.name, i), obs(sel), exp);
            if (i < total) tick();
        end
        last_ch[sel] = v.ch;
        last_d[sel] = (nb == 2) ? v.b1 : v.b0;
        tick();
        check($sformatf("%s_idle", v.name), obs(sel),
              mk(last_ch[sel], 1, 1, 1, 1, last_d[sel], 1, 0, 0));
    endtask

    initial begin
        vec_t v;
        logic bad;
        logic seen;

        tbl[0] = '{"wave_ch2", 1'b1, 2'd0, 16'h0003, 8'h03, 8'h00};
        tbl[1] = '{"freq_ch1", 1'b0, 2'd1, 16'hA55A, 8'hA5, 8'h5A};
        tbl[2] = '{"freq_ch2", 1'b1, 2'd1, 16'h00FF, 8'h00, 8'hFF};
        last_ch[0] = 1'b0; last_ch[1] = 1'b0;
        last_d[0] = 8'h00; last_d[1] = 8'h00;

        // Reset state, then ready from the first cycle out of reset.
        repeat (3) tick();
        check("rst_a", obs_a, mk(0, 1, 1, 1, 1, 8'h00, 0, 0, 0));
        check("rst_b", obs_b, mk(0, 1, 1, 1, 1, 8'h00, 0, 0, 0));
        rst = 1'b0;
        tick();
        check("ready_a", obs_a, mk(0, 1, 1, 1, 1, 8'h00, 1, 0, 0));
        check("ready_b", obs_b, mk(0, 1, 1, 1, 1, 8'h00, 1, 0, 0));

        for (int k = 0; k < 3; k++) run_cmd(0, tbl[k], 2, 4, 2);

        // Reserved register: err pulse only, then a phase write still works.
        cmd_ch = 1'b0; cmd_reg = 2'd3; cmd_data = 16'h1234; va = 1'b1;
        tick();
        va = 1'b0;
        check("rsvd_err", obs_a, mk(last_ch[0], 1, 1, 1, 1, last_d[0], 1, 0, 1));
        tick();
        check("rsvd_after", obs_a, mk(last_ch[0], 1, 1, 1, 1, last_d[0], 1, 0, 0));
        v = '{"pha_ch1", 1'b0, 2'd2, 16'h1280, 8'h80, 8'h00};
        run_cmd(0, v, 2, 4, 2);

        // Back-to-back: cmd_valid held; second command taken in the DONE cycle.
        cmd_ch = 1'b0; cmd_reg = 2'd2; cmd_data = 16'h0010; va = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 3) check("b2b_pha1", obs_a, mk(0, 1, 1, 1, 0, 8'h10, 0, 0, 0));
        end
        check("b2b_done1", obs_a, mk(0, 1, 1, 1, 1, 8'h10, 1, 1, 0));
        cmd_ch = 1'b1; cmd_data = 16'h0020;
        tick();
        va = 1'b0;
        check("b2b_setup2", obs_a, mk(1, 1, 1, 1, 1, 8'h20, 0, 0, 0));
        tick();
        tick();
        check("b2b_pha2", obs_a, mk(1, 1, 1, 1, 0, 8'h20, 0, 0, 0));
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            seen = a_done;
        end
        check("b2b_done2", {15'd0, seen}, 16'd1);
        tick();
        last_ch[0] = 1'b1; last_d[0] = 8'h20;
        check("b2b_idle", obs_a, mk(1, 1, 1, 1, 1, 8'h20, 1, 0, 0));

        // Reset during the fre_h pulse discards the command.
        cmd_ch = 1'b0; cmd_reg = 2'd1; cmd_data = 16'hA55A; va = 1'b1;
        tick();
        va = 1'b0;
        tick(); tick(); tick();
        check("mid_freh", obs_a, mk(0, 1, 0, 1, 1, 8'hA5, 0, 0, 0));
        rst = 1'b1;
        tick();
        check("mid_rst", obs_a, mk(0, 1, 1, 1, 1, 8'h00, 0, 0, 0));
        rst = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (!a_fre_l || !a_fre_h || a_done || !a_ready) bad = 1'b1;
        end
        check("mid_discard", {15'd0, bad}, 16'd0);
        check("mid_idle", obs_a, mk(0, 1, 1, 1, 1, 8'h00, 1, 0, 0));
        last_ch[0] = 1'b0; last_d[0] = 8'h00;
        last_ch[1] = 1'b0; last_d[1] = 8'h00;

        // Minimum timing instance: 1/1/1 cycles.
        run_cmd(1, tbl[0], 1, 1, 1);
        run_cmd(1, tbl[1], 1, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
